// File: rtl/eusci_baud_gen_pkg.sv
// Shared definitions for the eUSCI UART baud-rate scheduler.
package eusci_baud_gen_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int unsigned SUB_PERIODS = 16;
  localparam int unsigned SUB_W       = 4;
  localparam int unsigned IDX_W       = 3;
  localparam int unsigned BR_W        = 16;

  localparam logic [SUB_W-1:0] LAST_SUB = SUB_W'(SUB_PERIODS - 1);

  // Prescaler value 0 behaves as 1, so the reload never underflows.
  function automatic logic [BR_W-1:0] prescale_reload(input logic [BR_W-1:0] brx);
    return (brx == '0) ? '0 : brx - BR_W'(1);
  endfunction

endpackage

// File: rtl/eusci_baud_gen.sv
// Baud-rate scheduler: divides BRCLK into BITCLK (one pulse per bit) with
// optional 16x oversampling, UCBRFx first-stage and UCBRSx per-bit modulation.
module eusci_baud_gen
  import eusci_baud_gen_pkg::*;
(
  input  logic            BRCLK,
  input  logic            reset_n,
  input  logic            UCSWRST,
  input  logic            UCOS16,
  input  logic [BR_W-1:0] UCBRx,
  input  logic [3:0]      UCBRFx,
  input  logic [7:0]      UCBRSx,
  input  logic            TxBEN,
  input  logic            TxStart,
  output logic            BITCLK,
  output logic            BITCLK16,
  output logic            BaudBusy
);

  state_t           state;
  logic [BR_W-1:0]  cnt;
  logic [SUB_W-1:0] sub;
  logic [IDX_W-1:0] idx;
  logic             ext;

  logic [IDX_W-1:0] eff_idx;
  logic             mod_bit;
  logic             last_sub;
  logic             need_ext;
  logic [BR_W-1:0]  reload;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    eff_idx  = idx;
    if (TxStart) eff_idx = '0;
    mod_bit  = UCBRSx[eff_idx];
    last_sub = !UCOS16 || (sub == LAST_SUB);
    // At most one extension cycle per sub-period: UCBRFx never reaches j=15.
    need_ext = (UCOS16 && (sub < UCBRFx)) || (last_sub && mod_bit);
    reload   = prescale_reload(UCBRx);
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge BRCLK or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      sub      <= '0;
      idx      <= '0;
      ext      <= 1'b0;
      BITCLK   <= 1'b0;
      BITCLK16 <= 1'b0;
    end else begin
      BITCLK   <= 1'b0;
      BITCLK16 <= 1'b0;
      unique case (state)
        IDLE: begin
          if (TxBEN && !UCSWRST) begin
            state    <= RUN;
            BITCLK   <= 1'b1;
            BITCLK16 <= UCOS16;
            cnt      <= reload;
            sub      <= '0;
            idx      <= '0;
            ext      <= 1'b0;
          end
        end
        RUN: begin
          if (!TxBEN || UCSWRST) begin
            // Abort wins over a coinciding terminal count.
            state <= IDLE;
            cnt   <= '0;
            sub   <= '0;
            idx   <= '0;
            ext   <= 1'b0;
          end else if (cnt != '0) begin
            cnt <= cnt - BR_W'(1);
          end else if (!ext && need_ext) begin
            ext <= 1'b1;
          end else begin
            ext      <= 1'b0;
            cnt      <= reload;
            BITCLK16 <= UCOS16;
            if (last_sub) begin
              BITCLK <= 1'b1;
              sub    <= '0;
              idx    <= eff_idx + IDX_W'(1);
            end else begin
              sub <= sub + SUB_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign BaudBusy = (state == RUN);

endmodule

// File: tb/tb_eusci_baud_gen.sv
// Directed self-checking bench for eusci_baud_gen: pulse spacing, modulation,
// oversampling, abort/restart and reset behaviour.
module tb_eusci_baud_gen;

  logic        BRCLK = 1'b0;
  logic        reset_n = 1'b0;
  logic        UCSWRST = 1'b0;
  logic        UCOS16 = 1'b0;
  logic [15:0] UCBRx = 16'd0;
  logic [3:0]  UCBRFx = 4'd0;
  logic [7:0]  UCBRSx = 8'd0;
  logic        TxBEN = 1'b0;
  logic        TxStart = 1'b0;
  logic        BITCLK;
  logic        BITCLK16;
  logic        BaudBusy;

  int n_vec = 0;
  int n_err = 0;

  always #5 BRCLK = ~BRCLK;

  eusci_baud_gen dut (
    .BRCLK    (BRCLK),
    .reset_n  (reset_n),
    .UCSWRST  (UCSWRST),
    .UCOS16   (UCOS16),
    .UCBRx    (UCBRx),
    .UCBRFx   (UCBRFx),
    .UCBRSx   (UCBRSx),
    .TxBEN    (TxBEN),
    .TxStart  (TxStart),
    .BITCLK   (BITCLK),
    .BITCLK16 (BITCLK16),
    .BaudBusy (BaudBusy)
  );

  task automatic check_bit(input string tag, input logic observed, input logic expected);
    n_vec++;
    assert (observed === expected) else begin
      n_err++;
      $error("FAIL %s: observed %0b expected %0b", tag, observed, expected);
    end
  endtask

  task automatic check_int(input string tag, input int observed, input int expected);
    n_vec++;
    assert (observed === expected) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Cycles until the next BITCLK (sel16=0) or BITCLK16 (sel16=1) pulse, bounded.
  task automatic expect_gap(input bit sel16, input int expected, input string tag);
    int n = 0;
    do begin
      @(negedge BRCLK);
      n++;
    end while (!(sel16 ? BITCLK16 : BITCLK) && n < 200);
    check_int(tag, n, expected);
  endtask

  task automatic go_idle();
    TxBEN   = 1'b0;
    TxStart = 1'b0;
    UCSWRST = 1'b1;
    repeat (2) @(negedge BRCLK);
    UCSWRST = 1'b0;
  endtask

  task automatic start(input string tag);
    TxBEN = 1'b1;
    @(negedge BRCLK);
    check_bit({tag, "_first_bitclk"}, BITCLK, 1'b1);
    check_bit({tag, "_busy"}, BaudBusy, 1'b1);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge BRCLK);
    check_bit("rst_bitclk", BITCLK, 1'b0);
    check_bit("rst_bitclk16", BITCLK16, 1'b0);
    check_bit("rst_busy", BaudBusy, 1'b0);
    reset_n = 1'b1;
    @(negedge BRCLK);
    check_bit("idle_busy", BaudBusy, 1'b0);

    // Plain divide by 4: pulses at cycles 1,5,9,13
    UCBRx = 16'd4;
    start("div4");
    check_bit("div4_bitclk16_off", BITCLK16, 1'b0);
    for (int i = 0; i < 3; i++) expect_gap(0, 4, "div4_gap");
    go_idle();

    // UCBRx = 0 behaves as 1: pulse every cycle
    UCBRx = 16'd0;
    start("div0");
    for (int i = 0; i < 3; i++) expect_gap(0, 1, "div0_gap");
    go_idle();

    // Second-stage modulation on bit 0 with TxStart forcing index 0
    UCBRx   = 16'd4;
    UCBRSx  = 8'h01;
    TxStart = 1'b1;
    start("brs");
    expect_gap(0, 5, "brs_start_gap");
    TxStart = 1'b0;
    for (int i = 0; i < 7; i++) expect_gap(0, 4, "brs_data_gap");
    TxStart = 1'b1;
    expect_gap(0, 5, "brs_restart_gap");
    TxStart = 1'b0;
    expect_gap(0, 4, "brs_idx1_gap");
    TxStart = 1'b1;
    expect_gap(0, 5, "brs_force_idx0_gap");
    TxStart = 1'b0;
    expect_gap(0, 4, "brs_after_force_gap");
    go_idle();

    // Oversampling, UCBRx=1: BITCLK16 every cycle, BITCLK every 16
    UCOS16 = 1'b1;
    UCBRx  = 16'd1;
    UCBRFx = 4'd0;
    UCBRSx = 8'h00;
    start("os1");
    check_bit("os1_entry_bitclk16", BITCLK16, 1'b1);
    for (int j = 1; j <= 16; j++) begin
      @(negedge BRCLK);
      check_bit("os1_bitclk16", BITCLK16, 1'b1);
      check_bit("os1_bitclk", BITCLK, (j == 16));
    end
    go_idle();

    // Oversampling with both modulation stages: 3,3,3, 2x12, 3 -> 36
    UCBRx  = 16'd2;
    UCBRFx = 4'd3;
    UCBRSx = 8'hFF;
    start("os2");
    for (int j = 0; j < 16; j++) begin
      expect_gap(1, (j < 3 || j == 15) ? 3 : 2, "os2_sub_gap");
      check_bit("os2_coincide", BITCLK, (j == 15));
    end
    expect_gap(0, 36, "os2_bit_period");
    go_idle();

    // Mid-bit abort, 10 idle cycles, restart at index 0
    UCOS16 = 1'b0;
    UCBRx  = 16'd4;
    UCBRFx = 4'd0;
    UCBRSx = 8'h01;
    start("abort");
    expect_gap(0, 5, "abort_idx0_gap");
    expect_gap(0, 4, "abort_idx1_gap");
    @(negedge BRCLK);
    @(negedge BRCLK);
    TxBEN = 1'b0;
    @(negedge BRCLK);
    check_bit("abort_busy", BaudBusy, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge BRCLK);
      check_bit("abort_no_pulse", BITCLK, 1'b0);
    end
    start("restart");
    expect_gap(0, 5, "restart_idx0_gap");

    // TxBEN falls in the terminal-count cycle: no pulse, back to idle
    @(negedge BRCLK);
    @(negedge BRCLK);
    @(negedge BRCLK);
    TxBEN = 1'b0;
    @(negedge BRCLK);
    check_bit("tc_abort_no_pulse", BITCLK, 1'b0);
    check_bit("tc_abort_busy", BaudBusy, 1'b0);

    // Asynchronous reset while BITCLK and BITCLK16 are high
    UCOS16 = 1'b1;
    UCBRx  = 16'd1;
    UCBRFx = 4'd0;
    UCBRSx = 8'h00;
    start("arst");
    #1 reset_n = 1'b0;
    #1;
    check_bit("arst_bitclk", BITCLK, 1'b0);
    check_bit("arst_bitclk16", BITCLK16, 1'b0);
    check_bit("arst_busy", BaudBusy, 1'b0);
    @(negedge BRCLK);
    reset_n = 1'b1;
    @(negedge BRCLK);
    check_bit("arst_restart_bitclk", BITCLK, 1'b1);

    // Software reset: idle next cycle and held there
    UCSWRST = 1'b1;
    @(negedge BRCLK);
    check_bit("swrst_busy", BaudBusy, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge BRCLK);
      check_bit("swrst_no_pulse", BITCLK16, 1'b0);
      check_bit("swrst_hold_busy", BaudBusy, 1'b0);
    end
    UCSWRST = 1'b0;
    @(negedge BRCLK);
    check_bit("swrst_release_bitclk", BITCLK, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
